audio_i2s_tx: RTL and testbench
===============================

AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter BCK_DIV, default 4, meaning clk cycles per half period of i2s_bck (legal range 1..16).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1; 1 runs the serializer and 0 holds it idle.
REQ-005 SHALL have port left_audio, input, 16, the signed two's-complement left sample from the PSG.
REQ-006 SHALL have port right_audio, input, 16, the signed two's-complement right sample from the PSG.
REQ-007 SHALL have port next_sample, output, 1, a one-clk pulse that requests the PSG to compute its next sample.
REQ-008 SHALL have port i2s_bck, output, 1, the bit clock.
REQ-009 SHALL have port i2s_lrck, output, 1, word select: 0 = left slot, 1 = right slot.
REQ-010 SHALL have port i2s_data, output, 1, serial data, MSB first.

Function
REQ-011 SHALL keep internal counters div_cnt (0..BCK_DIV-1), phase (0 = bck low, 1 = bck high) and slot (0..63).
REQ-012 SHALL, on each enabled clk, increment div_cnt; at BCK_DIV-1 it wraps to 0 and toggles phase; when phase goes 1->0, slot increments and wraps 63->0.
REQ-013 SHALL make the frame period 128*BCK_DIV clk (512 clk at the default).
REQ-014 SHALL define the frame-start cycle as slot=0, phase=0, div_cnt=0 with enable=1.
REQ-015 SHALL, in the frame-start cycle, latch left_audio and right_audio into holding registers; inputs sampled at any other time SHALL NOT affect the current frame.
REQ-016 SHALL assert next_sample high for exactly one clk, in the cycle after each frame-start cycle, and SHALL hold it low otherwise.
REQ-017 SHALL drive all outputs from registers: i2s_bck = phase and i2s_lrck = (slot >= 32), each updated in the same edge as the counters.
REQ-018 SHALL drive i2s_data with the I2S one-bit delay:
- slots 1..16 carry L[15]..L[0];
- slots 33..48 carry R[15]..R[0];
- all other slots drive 0.
- i2s_data changes only at a phase 1->0 transition, so it is stable while i2s_bck is high.
REQ-019 SHALL pass sample bits through unaltered: 0x8000 and 0x7FFF are serialized bit-exact, with no saturation and no sign-extension into the padding slots.
REQ-020 SHALL, while enable=0, clear all counters and drive i2s_bck=0, i2s_lrck=0, i2s_data=0 and next_sample=0; the holding registers retain their values.
REQ-021 SHALL restart from slot 0 on an enable 0->1 transition; the first enabled cycle is a frame-start cycle.
REQ-022 SHALL give rst priority over enable when both change in the same cycle.

Reset
REQ-023 SHALL, while rst=1, clear div_cnt, phase, slot, both holding registers, i2s_bck, i2s_lrck, i2s_data and next_sample to 0.
REQ-024 SHALL abandon any partial frame on a mid-frame rst; the first enabled cycle after rst deasserts is a frame-start cycle, and next_sample pulses one clk later.

Structure
REQ-025 SHALL take SAMPLE_WIDTH=16, SLOT_WIDTH=32 and SLOTS_PER_FRAME=64 from the shared package audio_pkg, which is also used by psg.
REQ-026 SHALL be a single flat module with no sub-modules; the divider and the shifter are local always blocks.

Verification
REQ-027 SHALL cover reset: rst held 3 clk, then released with enable=1 -> next_sample pulses at clk 1, 513 and 1025 after release (BCK_DIV=4), and all outputs are 0 during rst.
REQ-028 SHALL cover data: left=0xA5C3, right=0x8001 -> i2s_data in slots 1..16 reads 1010010111000011, slots 33..48 read 1000000000000001, and every other slot reads 0.
REQ-029 SHALL cover mid-frame input change: inputs changed at slot 10 -> the current frame is unchanged and the new values appear in the next frame.
REQ-030 SHALL cover enable toggling: enable dropped at slot 20 for 7 clk -> outputs go 0 in the next clk, and on re-enable next_sample pulses one clk after the first enabled cycle and slot restarts at 0.
REQ-031 SHALL cover the divider boundary: BCK_DIV=1 -> i2s_bck toggles every clk and the frame is 128 clk; full-scale samples 0x7FFF/0x8000 serialize bit-exact.
REQ-032 SHALL cover reset priority: rst=1 and enable 0->1 in the same cycle -> the block stays in reset and the first frame starts on the cycle after rst deasserts.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio constants for the PSG and the I2S serializer, plus the
// slot-to-sample-bit mapping used on the serial line.
package audio_pkg;
   localparam int SAMPLE_WIDTH    = 16;
   localparam int SLOT_WIDTH      = 32;
   localparam int SLOTS_PER_FRAME = 64;
   localparam int SLOT_W          = $clog2(SLOTS_PER_FRAME);

   // Standard I2S: the MSB sits one slot after the word-select edge, and the
   // slots after the LSB are zero padding.
   function automatic logic slot_bit(input logic [SLOT_W-1:0]       slot,
                                     input logic [SAMPLE_WIDTH-1:0] l,
                                     input logic [SAMPLE_WIDTH-1:0] r);
      int                      s;
      logic [SAMPLE_WIDTH-1:0] sh;
      s  = int'(slot);
      sh = '0;
      if (s >= 1 && s <= SAMPLE_WIDTH)
         sh = l << (s - 1);
      else if (s >= SLOT_WIDTH + 1 && s <= SLOT_WIDTH + SAMPLE_WIDTH)
         sh = r << (s - SLOT_WIDTH - 1);
      return sh[SAMPLE_WIDTH-1];
   endfunction
endpackage

// File: rtl/audio_i2s_tx.sv
// Stereo I2S transmitter: divides clk into the bit clock, latches one L/R pair
// per 64-slot frame and shifts it out MSB first with the one-bit I2S delay.
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int BCK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] left_audio,
   input  logic [15:0] right_audio,
   output logic        next_sample,
   output logic        i2s_bck,
   output logic        i2s_lrck,
   output logic        i2s_data
);
   localparam int               DIV_W   = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCK_DIV - 1);

   logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
   logic                    phase_q, phase_d;
   logic [SLOT_W-1:0]       slot_q, slot_d;
   logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d;
   logic [SAMPLE_WIDTH-1:0] hold_r_q, hold_r_d;
   logic                    next_sample_q, next_sample_d;
   logic                    bck_q, bck_d;
   logic                    lrck_q, lrck_d;
   logic                    data_q, data_d;
   logic                    frame_start;

   always_comb begin
      div_cnt_d     = div_cnt_q;
      phase_d       = phase_q;
      slot_d        = slot_q;
      hold_l_d      = hold_l_q;
      hold_r_d      = hold_r_q;
      next_sample_d = 1'b0;
      bck_d         = 1'b0;
      lrck_d        = 1'b0;
      data_d        = 1'b0;
      frame_start   = enable && (slot_q == '0) && !phase_q && (div_cnt_q == '0);

      if (!enable) begin
         // Idle: counters parked at frame start, holding registers kept.
         div_cnt_d = '0;
         phase_d   = 1'b0;
         slot_d    = '0;
      end else begin
         next_sample_d = frame_start;
         data_d        = data_q;
         if (frame_start) begin
            hold_l_d = left_audio;
            hold_r_d = right_audio;
         end
         if (div_cnt_q == DIV_MAX) begin
            div_cnt_d = '0;
            phase_d   = ~phase_q;
            // Falling bck edge: advance the slot and present its bit, so data
            // is stable for the whole high half that follows.
            if (phase_q) begin
               slot_d = slot_q + SLOT_W'(1);
               data_d = slot_bit(slot_d, hold_l_q, hold_r_q);
            end
         end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
         end
         bck_d  = phase_d;
         lrck_d = (slot_d >= SLOT_W'(SLOT_WIDTH));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_q     <= '0;
         phase_q       <= 1'b0;
         slot_q        <= '0;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         next_sample_q <= 1'b0;
         bck_q         <= 1'b0;
         lrck_q        <= 1'b0;
         data_q        <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         phase_q       <= phase_d;
         slot_q        <= slot_d;
         hold_l_q      <= hold_l_d;
         hold_r_q      <= hold_r_d;
         next_sample_q <= next_sample_d;
         bck_q         <= bck_d;
         lrck_q        <= lrck_d;
         data_q        <= data_d;
      end
   end

   assign next_sample = next_sample_q;
   assign i2s_bck     = bck_q;
   assign i2s_lrck    = lrck_q;
   assign i2s_data    = data_q;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: BCK_DIV=4 and BCK_DIV=1 instances share stimulus and
// are compared every clk against a frame-position arithmetic model.
module tb_audio_i2s_tx;
   logic        clk = 1'b0;
   logic        rst, enable;
   logic [15:0] left_audio, right_audio;
   logic        ns4, bck4, lr4, d4;
   logic        ns1, bck1, lr1, d1;

   int          tests = 0;
   int          fails = 0;
   int          n4, n1;
   logic [15:0] ml4, mr4, ml1, mr1;
   logic [3:0]  exp4, exp1;

   always #5 clk = ~clk;

   audio_i2s_tx #(.BCK_DIV(4)) dut4 (
      .clk(clk), .rst(rst), .enable(enable),
      .left_audio(left_audio), .right_audio(right_audio),
      .next_sample(ns4), .i2s_bck(bck4), .i2s_lrck(lr4), .i2s_data(d4));

   audio_i2s_tx #(.BCK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .enable(enable),
      .left_audio(left_audio), .right_audio(right_audio),
      .next_sample(ns1), .i2s_bck(bck1), .i2s_lrck(lr1), .i2s_data(d1));

   // Outputs after the n-th enabled edge: frame is 128*d clk, each bck half is
   // d clk, a slot is one full bck period; slot s>0 carries bit (16-s) of L or
   // (48-s) of R, and next_sample follows the first cycle of every frame.
   function automatic logic [3:0] exp_out(input int d, input int n,
                                          input logic [15:0] l, input logic [15:0] r);
      int   f, p, ph, s;
      logic dat;
      f   = 128 * d;
      p   = n % f;
      ph  = (p / d) % 2;
      s   = p / (2 * d);
      dat = 1'b0;
      if (s >= 1 && s <= 16)  dat = l[4'(16 - s)];
      if (s >= 33 && s <= 48) dat = r[4'(48 - s)];
      return {((n - 1) % f == 0), ph[0], (s >= 32), dat};
   endfunction

   // Advance one clk and update the model; comparisons are done by callers.
   task automatic tick();
      if (!rst && enable) begin
         if (n4 % 512 == 0) begin ml4 = left_audio; mr4 = right_audio; end
         if (n1 % 128 == 0) begin ml1 = left_audio; mr1 = right_audio; end
      end
      @(posedge clk);
      #1;
      if (rst) begin
         n4 = 0; n1 = 0; ml4 = '0; mr4 = '0; ml1 = '0; mr1 = '0;
      end else if (!enable) begin
         n4 = 0; n1 = 0;
      end else begin
         n4++; n1++;
      end
      exp4 = (rst || !enable) ? 4'b0 : exp_out(4, n4, ml4, mr4);
      exp1 = (rst || !enable) ? 4'b0 : exp_out(1, n1, ml1, mr1);
   endtask

   task automatic do_reset();
      rst = 1'b1; enable = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0;
      left_audio = 16'($urandom); right_audio = 16'($urandom);
      for (int k = 0; k < 3; k++) begin
         tick();
         tests++;
         if ({ns4, bck4, lr4, d4, ns1, bck1, lr1, d1} !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs clk%0d got %b%b%b%b %b%b%b%b want 0",
                     k, ns4, bck4, lr4, d4, ns1, bck1, lr1, d1);
         end
      end
      rst = 1'b0; enable = 1'b1;
      for (int k = 1; k <= 1030; k++) begin
         tick();
         tests++;
         if (ns4 !== (k == 1 || k == 513 || k == 1025)) begin
            fails++;
            $display("FAIL reset_next_sample clk%0d got %b", k, ns4);
         end
         tests++;
         if ({ns4, bck4, lr4, d4} !== exp4) begin
            fails++;
            $display("FAIL reset_model4 n=%0d got %b%b%b%b want %b", n4, ns4, bck4, lr4, d4, exp4);
         end
      end
   endtask

   task automatic test_data();
      logic [63:0] bits;
      logic        pb;
      int          rises;
      bits = '0; pb = 1'b0; rises = 0;
      do_reset();
      left_audio = 16'hA5C3; right_audio = 16'h8001; enable = 1'b1;
      for (int k = 1; k <= 512; k++) begin
         tick();
         if (bck4 && !pb) begin bits = {bits[62:0], d4}; rises++; end
         pb = bck4;
         tests++;
         if ({ns4, bck4, lr4, d4} !== exp4) begin
            fails++;
            $display("FAIL data_model4 n=%0d got %b%b%b%b want %b", n4, ns4, bck4, lr4, d4, exp4);
         end
      end
      tests++;
      if (rises !== 64) begin fails++; $display("FAIL data_rises got %0d want 64", rises); end
      tests++;
      if (bits[62:47] !== 16'hA5C3) begin
         fails++; $display("FAIL data_left got %h want a5c3", bits[62:47]);
      end
      tests++;
      if (bits[30:15] !== 16'h8001) begin
         fails++; $display("FAIL data_right got %h want 8001", bits[30:15]);
      end
      tests++;
      if ({bits[63], bits[46:31], bits[14:0]} !== 32'h0) begin
         fails++; $display("FAIL data_padding got %h want 0", {bits[63], bits[46:31], bits[14:0]});
      end
   endtask

   task automatic test_mid_change();
      logic [127:0] bits;
      logic         pb;
      logic [15:0]  l1, r1, l2, r2;
      bits = '0; pb = 1'b0;
      l1 = 16'($urandom); r1 = 16'($urandom); l2 = ~l1; r2 = ~r1;
      do_reset();
      left_audio = l1; right_audio = r1; enable = 1'b1;
      for (int k = 1; k <= 1024; k++) begin
         if (k == 81) begin left_audio = l2; right_audio = r2; end
         tick();
         if (bck4 && !pb) bits = {bits[126:0], d4};
         pb = bck4;
         tests++;
         if ({ns4, bck4, lr4, d4} !== exp4) begin
            fails++;
            $display("FAIL mid_model4 n=%0d got %b%b%b%b want %b", n4, ns4, bck4, lr4, d4, exp4);
         end
      end
      tests++;
      if ({bits[126:111], bits[94:79]} !== {l1, r1}) begin
         fails++; $display("FAIL mid_frame0 got %h %h want %h %h", bits[126:111], bits[94:79], l1, r1);
      end
      tests++;
      if ({bits[62:47], bits[30:15]} !== {l2, r2}) begin
         fails++; $display("FAIL mid_frame1 got %h %h want %h %h", bits[62:47], bits[30:15], l2, r2);
      end
   endtask

   task automatic test_enable_toggle();
      do_reset();
      left_audio = 16'($urandom); right_audio = 16'($urandom); enable = 1'b1;
      for (int k = 0; k < 160; k++) begin
         tick();
         tests++;
         if ({ns4, bck4, lr4, d4} !== exp4) begin
            fails++;
            $display("FAIL en_pre_model4 n=%0d got %b%b%b%b want %b", n4, ns4, bck4, lr4, d4, exp4);
         end
      end
      enable = 1'b0;
      for (int k = 0; k < 7; k++) begin
         tick();
         tests++;
         if ({ns4, bck4, lr4, d4, ns1, bck1, lr1, d1} !== 8'h00) begin
            fails++;
            $display("FAIL en_idle clk%0d got %b%b%b%b %b%b%b%b want 0",
                     k, ns4, bck4, lr4, d4, ns1, bck1, lr1, d1);
         end
      end
      enable = 1'b1;
      tick();
      tests++;
      if ({ns4, bck4, lr4, ns1} !== 4'b1001) begin
         fails++; $display("FAIL en_restart got ns4=%b bck4=%b lr4=%b ns1=%b want 1 0 0 1", ns4, bck4, lr4, ns1);
      end
      for (int k = 2; k <= 600; k++) begin
         tick();
         tests++;
         if ({ns4, bck4, lr4, d4} !== exp4 || {ns1, bck1, lr1, d1} !== exp1) begin
            fails++;
            $display("FAIL en_post_model n=%0d got %b%b%b%b/%b%b%b%b want %b/%b",
                     n4, ns4, bck4, lr4, d4, ns1, bck1, lr1, d1, exp4, exp1);
         end
      end
   endtask

   task automatic test_full_scale();
      logic [127:0] bits;
      logic         pb;
      bits = '0; pb = 1'b0;
      do_reset();
      left_audio = 16'h7FFF; right_audio = 16'h8000; enable = 1'b1;
      for (int k = 1; k <= 256; k++) begin
         tick();
         tests++;
         if (bck1 !== k[0]) begin
            fails++; $display("FAIL div1_bck clk%0d got %b want %b", k, bck1, k[0]);
         end
         tests++;
         if (ns1 !== (k == 1 || k == 129)) begin
            fails++; $display("FAIL div1_frame clk%0d next_sample got %b", k, ns1);
         end
         if (bck1 && !pb) bits = {bits[126:0], d1};
         pb = bck1;
         tests++;
         if ({ns1, bck1, lr1, d1} !== exp1) begin
            fails++;
            $display("FAIL div1_model n=%0d got %b%b%b%b want %b", n1, ns1, bck1, lr1, d1, exp1);
         end
      end
      tests++;
      if ({bits[126:111], bits[94:79], bits[62:47], bits[30:15]} !== 64'h7FFF_8000_7FFF_8000) begin
         fails++;
         $display("FAIL div1_fullscale got %h %h %h %h want 7fff 8000 7fff 8000",
                  bits[126:111], bits[94:79], bits[62:47], bits[30:15]);
      end
      tests++;
      if ({bits[127], bits[110:95], bits[78:64], bits[63], bits[46:31], bits[14:0]} !== 64'h0) begin
         fails++; $display("FAIL div1_padding nonzero padding bits");
      end
   endtask

   task automatic test_rst_priority();
      enable = 1'b0;
      tick();
      rst = 1'b1; enable = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         tests++;
         if ({ns4, bck4, lr4, d4, ns1, bck1, lr1, d1} !== 8'h00) begin
            fails++;
            $display("FAIL prio_in_reset clk%0d got %b%b%b%b %b%b%b%b want 0",
                     k, ns4, bck4, lr4, d4, ns1, bck1, lr1, d1);
         end
      end
      rst = 1'b0;
      tick();
      tests++;
      if ({ns4, ns1} !== 2'b11) begin
         fails++; $display("FAIL prio_first_frame got ns4=%b ns1=%b want 1 1", ns4, ns1);
      end
      for (int k = 2; k <= 20; k++) begin
         tick();
         tests++;
         if ({ns4, bck4, lr4, d4} !== exp4) begin
            fails++;
            $display("FAIL prio_model4 n=%0d got %b%b%b%b want %b", n4, ns4, bck4, lr4, d4, exp4);
         end
      end
   endtask

   task automatic test_random_stream();
      do_reset();
      enable = 1'b1;
      for (int k = 1; k <= 1100; k++) begin
         left_audio = 16'($urandom); right_audio = 16'($urandom);
         tick();
         tests++;
         if ({ns4, bck4, lr4, d4} !== exp4 || {ns1, bck1, lr1, d1} !== exp1) begin
            fails++;
            $display("FAIL rand_model n=%0d got %b%b%b%b/%b%b%b%b want %b/%b",
                     n4, ns4, bck4, lr4, d4, ns1, bck1, lr1, d1, exp4, exp1);
         end
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; left_audio = '0; right_audio = '0;
      n4 = 0; n1 = 0; ml4 = '0; mr4 = '0; ml1 = '0; mr1 = '0;
      exp4 = '0; exp1 = '0;
      test_reset();
      test_data();
      test_mid_change();
      test_enable_toggle();
      test_full_scale();
      test_rst_priority();
      test_random_stream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
